// File: rtl/serial_fa_sched.sv
// Round-robin scheduler sharing one bit-serial full adder between two requesters.
// Computes W-bit add/subtract LSB first, one bit per clock; all outputs registered.
module serial_fa_sched #(
  parameter int unsigned W = 8
) (
  input  logic         C,
  input  logic         R,
  input  logic         REQ0,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic         SUB0,
  output logic         ACK0,
  input  logic         REQ1,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  input  logic         SUB1,
  output logic         ACK1,
  output logic [W-1:0] Y,
  output logic         CO,
  output logic         GNT,
  output logic         DONE,
  output logic         BUSY
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-2:0]    r_res;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_owner;
  logic            r_last;

  logic            w_req;
  logic            w_win;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_sub;
  logic            w_sum;
  logic            w_cy;
  logic            w_last_step;

  always_comb begin
    w_req       = REQ0 | REQ1;
    w_win       = (REQ0 & REQ1) ? ~r_last : REQ1;
    w_a         = w_win ? A1 : A0;
    w_b         = w_win ? B1 : B0;
    w_sub       = w_win ? SUB1 : SUB0;
    w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
    w_cy        = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_last_step = (r_cnt == CW'(W - 1));
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_nxt = RUN;
      RUN:     if (w_last_step) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) r_state <= IDLE;
    else   r_state <= w_state_nxt;
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      Y       <= '0;
      CO      <= 1'b0;
      GNT     <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      DONE <= 1'b0;
      BUSY <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_a     <= w_a;
            r_b     <= w_sub ? ~w_b : w_b;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_last  <= w_win;
            ACK0    <= ~w_win;
            ACK1    <= w_win;
          end
        end
        RUN: begin
          r_carry <= w_cy;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= (W-1)'({w_sum, r_res} >> 1);
          r_cnt   <= r_cnt + CW'(1);
          // The final sum bit is merged straight into Y so the result lands with DONE.
          if (w_last_step) begin
            Y    <= {w_sum, r_res};
            CO   <= w_cy;
            GNT  <= r_owner;
            DONE <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fa_sched.sv
// Self-checking bench for serial_fa_sched: directed cases plus randomized ops
// against a transaction-level arithmetic and round-robin reference.
module tb_serial_fa_sched;
  localparam int unsigned W = 8;

  logic         C = 1'b0;
  logic         R = 1'b1;
  logic         REQ0 = 1'b0, SUB0 = 1'b0, REQ1 = 1'b0, SUB1 = 1'b0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         ACK0, ACK1, CO, GNT, DONE, BUSY;
  logic [W-1:0] Y;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit m_last   = 1'b1;

  serial_fa_sched #(.W(W)) dut (
    .C(C), .R(R),
    .REQ0(REQ0), .A0(A0), .B0(B0), .SUB0(SUB0), .ACK0(ACK0),
    .REQ1(REQ1), .A1(A1), .B1(B1), .SUB1(SUB1), .ACK1(ACK1),
    .Y(Y), .CO(CO), .GNT(GNT), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 C = ~C;
  always @(posedge C) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Unsigned arithmetic view: add gives the W+1 bit sum, sub gives A-B and no-borrow flag.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  task automatic wait_ack(output bit got, output int at);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge C);
      if (ACK0 | ACK1) begin
        got = 1'b1;
        at  = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done(output bit got, output int at);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge C);
      if (DONE) begin
        got = 1'b1;
        at  = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge C);
    R = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    #1;
    check("reset_outs", 32'({Y, CO, GNT, DONE, BUSY, ACK0, ACK1}), 32'd0);
    @(negedge C);
    R = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic run_op(input bit r0, input bit r1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                        input string tag);
    bit got;
    bit win;
    int t_ack, t_done;
    logic [W:0] e;
    A0 = a0; B0 = b0; SUB0 = s0;
    A1 = a1; B1 = b1; SUB1 = s1;
    REQ0 = r0; REQ1 = r1;
    win = (r0 & r1) ? ~m_last : r1;
    e = win ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
    wait_ack(got, t_ack);
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_ack_pair"}, 32'({ACK1, ACK0}), win ? 32'd2 : 32'd1);
    if (win) REQ1 = 1'b0;
    else     REQ0 = 1'b0;
    m_last = win;
    wait_done(got, t_done);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_latency"}, t_done - t_ack, W);
    check({tag, "_result"}, 32'({CO, Y}), 32'(e));
    check({tag, "_gnt"}, 32'(GNT), 32'(win));
    check({tag, "_busy"}, 32'(BUSY), 32'd1);
  endtask

  initial begin
    bit got;
    int t_ack, t_done, t_prev, n_done, bad;
    logic [W:0] e0, e1;
    logic [W-1:0] ra, rb;

    #1;
    check("reset_hold", 32'({Y, CO, GNT, DONE, BUSY, ACK0, ACK1}), 32'd0);
    repeat (2) @(negedge C);
    R = 1'b0;

    run_op(1, 0, 8'h35, 8'h0A, 0, 8'h00, 8'h00, 0, "t1_add");
    check("t1_const", 32'({CO, Y}), 32'h03F);
    run_op(0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h01, 0, "t2_wrap");
    check("t2_const", 32'({CO, Y}), 32'h100);
    run_op(0, 1, 8'h00, 8'h00, 0, 8'h80, 8'h80, 0, "t2_msb");
    run_op(1, 0, 8'h10, 8'h20, 1, 8'h00, 8'h00, 0, "t3_sub_neg");
    check("t3_const", 32'({CO, Y}), 32'h0F0);
    run_op(1, 0, 8'h20, 8'h10, 1, 8'h00, 8'h00, 0, "t3_sub_pos");
    run_op(1, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, "t3_sub_zero");
    check("t3z_const", 32'({CO, Y}), 32'h100);

    // Both requesters held high: strict alternation at W+2 spacing.
    do_reset();
    A0 = 8'h12; B0 = 8'h34; SUB0 = 0;
    A1 = 8'h90; B1 = 8'hA5; SUB1 = 1;
    e0 = ref_op(A0, B0, SUB0);
    e1 = ref_op(A1, B1, SUB1);
    REQ0 = 1; REQ1 = 1;
    t_prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(got, t_ack);
      check("t4_ack_seen", 32'(got), 32'd1);
      check("t4_ack_pair", 32'({ACK1, ACK0}), (k % 2 == 1) ? 32'd2 : 32'd1);
      wait_done(got, t_done);
      check("t4_done_seen", 32'(got), 32'd1);
      check("t4_gnt", 32'(GNT), 32'(k % 2));
      check("t4_result", 32'({CO, Y}), (k % 2 == 1) ? 32'(e1) : 32'(e0));
      if (k > 0) check("t4_spacing", t_done - t_prev, W + 2);
      t_prev = t_done;
    end
    REQ0 = 0; REQ1 = 0;
    m_last = 1'b1;

    // Reset during the 4th RUN cycle discards the op.
    do_reset();
    A0 = 8'h55; B0 = 8'h11; SUB0 = 0; REQ0 = 1;
    wait_ack(got, t_ack);
    check("t5_ack_seen", 32'(got), 32'd1);
    REQ0 = 0;
    repeat (3) @(negedge C);
    check("t5_busy_before", 32'(BUSY), 32'd1);
    R = 1;
    #1;
    check("t5_async_clear", 32'({Y, CO, GNT, DONE, BUSY, ACK0, ACK1}), 32'd0);
    @(negedge C);
    R = 0;
    m_last = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge C);
      if (DONE) n_done++;
    end
    check("t5_no_done", n_done, 0);
    run_op(1, 0, 8'h01, 8'h02, 0, 8'h00, 8'h00, 0, "t5_after");

    // Late request from requester 1 waits for IDLE; Y holds until its FIN.
    ra = 8'hC3; rb = 8'h3C;
    e0 = ref_op(ra, rb, 1'b0);
    e1 = ref_op(8'h77, 8'h99, 1'b1);
    A0 = ra; B0 = rb; SUB0 = 0; REQ0 = 1;
    wait_ack(got, t_ack);
    check("t6_ack0", 32'({ACK1, ACK0}), 32'd1);
    REQ0 = 0;
    A1 = 8'h77; B1 = 8'h99; SUB1 = 1; REQ1 = 1;
    bad = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge C);
      if (ACK1) bad++;
      if (DONE) got = 1;
      else if ({CO, Y} !== 9'h003) bad++;
    end
    t_done = cyc;
    check("t6_done0_seen", 32'(got), 32'd1);
    check("t6_no_early_ack_or_hold", bad, 0);
    check("t6_result0", 32'({CO, Y}), 32'(e0));
    wait_ack(got, t_ack);
    check("t6_ack1", 32'({ACK1, ACK0}), 32'd2);
    check("t6_ack1_gap", t_ack - t_done, 2);
    check("t6_y_held", 32'({CO, Y}), 32'(e0));
    REQ1 = 0;
    m_last = 1'b1;
    wait_done(got, t_done);
    check("t6_done1_seen", 32'(got), 32'd1);
    check("t6_result1", 32'({CO, Y}), 32'(e1));
    check("t6_gnt1", 32'(GNT), 32'd1);

    // Randomized traffic with mixed single and simultaneous requests.
    for (int n = 0; n < 40; n++) begin
      bit q0, q1;
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      if (!q0 && !q1) q0 = 1;
      run_op(q0, q1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rnd");
    end
    REQ0 = 0; REQ1 = 0;
    repeat (4) @(negedge C);
    check("final_idle", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
